// File: rtl/vga_mon_pkg.sv
// Shared constants and helpers for the TinyVGA frame monitor: pin indices,
// default 640x480 timing, the lock-state type and small width/bit helpers.
package vga_mon_pkg;

    // TinyVGA uo_out pin order {HS,B0,G0,R0,VS,B1,G1,R1}
    localparam int HS_BIT = 7;
    localparam int B0_BIT = 6;
    localparam int G0_BIT = 5;
    localparam int R0_BIT = 4;
    localparam int VS_BIT = 3;
    localparam int B1_BIT = 2;
    localparam int G1_BIT = 1;
    localparam int R1_BIT = 0;

    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_TOTAL  = 525;

    localparam int LINE_CNT_W  = 11;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic [0:0] {
        MON_UNLOCKED = 1'b0,
        MON_LOCKED   = 1'b1
    } mon_state_e;

    // Counter width that holds max_val with one spare bit of headroom before saturation
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

    // Colour bits in CRC order {R1,R0,G1,G0,B1,B0}
    function automatic logic [5:0] pixel_bits(input logic [7:0] v);
        return {v[R1_BIT], v[R0_BIT], v[G1_BIT], v[G0_BIT], v[B1_BIT], v[B0_BIT]};
    endfunction

endpackage

// File: rtl/vga_crc_step.sv
// Combinational CRC update: shifts six data bits, MSB first, into an
// MSB-first CRC with the given normal-form generator polynomial.
module vga_crc_step #(
    parameter int               CRC_W    = 32,
    parameter logic [CRC_W-1:0] CRC_POLY = 32'h04C1_1DB7
) (
    input  logic [CRC_W-1:0] crc_i,
    input  logic [5:0]       data_i,
    output logic [CRC_W-1:0] crc_o
);

    logic [CRC_W-1:0] acc_s;

    // Bit-serial LFSR unrolled over the six data bits
    always_comb begin
        acc_s = crc_i;
        for (int i = 5; i >= 0; i--) begin
            if (acc_s[CRC_W-1] ^ data_i[i]) begin
                acc_s = (acc_s << 1) ^ CRC_POLY;
            end else begin
                acc_s = acc_s << 1;
            end
        end
        crc_o = acc_s;
    end

endmodule

// File: rtl/vga_frame_monitor.sv
// Recovers line/frame timing from a TinyVGA stream, CRCs the active pixels and
// publishes CRC, line count and timing-error flags at every frame boundary.
module vga_frame_monitor
    import vga_mon_pkg::*;
#(
    parameter int               H_SYNC   = DEF_H_SYNC,
    parameter int               H_BACK   = DEF_H_BACK,
    parameter int               H_ACTIVE = DEF_H_ACTIVE,
    parameter int               H_TOTAL  = DEF_H_TOTAL,
    parameter int               V_SYNC   = DEF_V_SYNC,
    parameter int               V_BACK   = DEF_V_BACK,
    parameter int               V_ACTIVE = DEF_V_ACTIVE,
    parameter int               V_TOTAL  = DEF_V_TOTAL,
    parameter int               SYNC_POL = 0,
    parameter int               CRC_W    = 32,
    parameter logic [CRC_W-1:0] CRC_POLY = 32'h04C1_1DB7,
    parameter logic [CRC_W-1:0] CRC_INIT = {CRC_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [7:0]             vga_in,
    output logic                   frame_valid,
    output logic [CRC_W-1:0]       frame_crc,
    output logic [LINE_CNT_W-1:0]  lines_seen,
    output logic                   frame_err,
    output logic                   line_err,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam int H_W = cnt_width(H_TOTAL);
    localparam int V_W = LINE_CNT_W;
    localparam logic POL = (SYNC_POL != 0);
    localparam logic [7:0] IDLE_IN = POL ? 8'h00 : 8'h88;
    localparam logic [H_W-1:0] H_MAX = {H_W{1'b1}};
    localparam logic [V_W-1:0] V_MAX = {V_W{1'b1}};
    localparam logic [H_W-1:0] HA_LO = H_W'(H_SYNC + H_BACK);
    localparam logic [H_W-1:0] HA_HI = H_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [V_W-1:0] VA_LO = V_W'(V_SYNC + V_BACK);
    localparam logic [V_W-1:0] VA_HI = V_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [H_W:0]   H_LEN = (H_W + 1)'(H_TOTAL);
    localparam logic [V_W-1:0] V_LEN = V_W'(V_TOTAL);
    localparam logic [FRAME_CNT_W-1:0] FC_MAX = {FRAME_CNT_W{1'b1}};

    logic [7:0]             vga_q, vga_d, vga_prev_q, vga_prev_d;
    logic [H_W-1:0]         h_cnt_q, h_cnt_d, h_cur_s;
    logic [V_W-1:0]         v_cnt_q, v_cnt_d, v_cur_s;
    mon_state_e             state_q, state_d;
    logic                   hs_seen_q, hs_seen_d;
    logic                   line_acc_q, line_acc_d;
    logic [CRC_W-1:0]       crc_q, crc_d, crc_step_s;
    logic                   frame_valid_q, frame_valid_d;
    logic [CRC_W-1:0]       frame_crc_q, frame_crc_d;
    logic [V_W-1:0]         lines_seen_q, lines_seen_d;
    logic                   frame_err_q, frame_err_d;
    logic                   line_err_q, line_err_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;

    logic       hs_now_s, hs_prev_s, vs_now_s, vs_prev_s;
    logic       hs_lead_s, vs_lead_s;
    logic       pix_active_s, line_bad_s, publish_s;
    logic [5:0] pix_data_s;

    assign pix_data_s = pixel_bits(vga_q);

    vga_crc_step #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY)
    ) u_crc_step (
        .crc_i  (crc_q),
        .data_i (pix_data_s),
        .crc_o  (crc_step_s)
    );

    // Input capture, sync normalisation, edge detection and current h/v position
    always_comb begin
        if (ena) begin
            vga_d      = vga_in;
            vga_prev_d = vga_q;
        end else begin
            vga_d      = vga_q;
            vga_prev_d = vga_prev_q;
        end

        hs_now_s  = ~(vga_q[HS_BIT] ^ POL);
        hs_prev_s = ~(vga_prev_q[HS_BIT] ^ POL);
        vs_now_s  = ~(vga_q[VS_BIT] ^ POL);
        vs_prev_s = ~(vga_prev_q[VS_BIT] ^ POL);
        hs_lead_s = ena & hs_now_s & ~hs_prev_s;
        vs_lead_s = ena & vs_now_s & ~vs_prev_s;

        if (hs_lead_s) begin
            h_cur_s = {H_W{1'b0}};
        end else if (h_cnt_q == H_MAX) begin
            h_cur_s = H_MAX;
        end else begin
            h_cur_s = h_cnt_q + {{(H_W-1){1'b0}}, 1'b1};
        end

        // A coincident hsync edge is the first line of the new frame
        if (vs_lead_s) begin
            v_cur_s = hs_lead_s ? {{(V_W-1){1'b0}}, 1'b1} : {V_W{1'b0}};
        end else if (hs_lead_s && (v_cnt_q != V_MAX)) begin
            v_cur_s = v_cnt_q + {{(V_W-1){1'b0}}, 1'b1};
        end else begin
            v_cur_s = v_cnt_q;
        end

        if (ena) begin
            h_cnt_d = h_cur_s;
            v_cnt_d = v_cur_s;
        end else begin
            h_cnt_d = h_cnt_q;
            v_cnt_d = v_cnt_q;
        end
    end

    // Lock FSM, line-length check, CRC accumulation and frame publication
    always_comb begin
        state_d = state_q;
        case (state_q)
            MON_UNLOCKED: begin
                if (vs_lead_s) begin
                    state_d = MON_LOCKED;
                end else begin
                    state_d = MON_UNLOCKED;
                end
            end
            MON_LOCKED:   state_d = MON_LOCKED;
            default:      state_d = MON_UNLOCKED;
        endcase

        publish_s    = vs_lead_s & (state_q == MON_LOCKED);
        pix_active_s = ena & (state_q == MON_LOCKED) &
                       (v_cur_s >= VA_LO) & (v_cur_s < VA_HI) &
                       (h_cur_s >= HA_LO) & (h_cur_s < HA_HI);
        line_bad_s   = hs_lead_s & (state_q == MON_LOCKED) & hs_seen_q &
                       (({1'b0, h_cnt_q} + {{H_W{1'b0}}, 1'b1}) != H_LEN);

        hs_seen_d = hs_seen_q | (hs_lead_s & ((state_q == MON_LOCKED) | vs_lead_s));

        if (publish_s) begin
            line_acc_d = line_bad_s;
            crc_d      = CRC_INIT;
        end else begin
            line_acc_d = line_acc_q | line_bad_s;
            crc_d      = pix_active_s ? crc_step_s : crc_q;
        end

        frame_valid_d = publish_s;
        frame_crc_d   = frame_crc_q;
        lines_seen_d  = lines_seen_q;
        frame_err_d   = frame_err_q;
        line_err_d    = line_err_q;
        frame_count_d = frame_count_q;
        if (publish_s) begin
            frame_crc_d   = crc_q;
            lines_seen_d  = v_cnt_q;
            line_err_d    = line_acc_q;
            frame_err_d   = (v_cnt_q != V_LEN) | line_acc_q;
            frame_count_d = (frame_count_q == FC_MAX) ? FC_MAX :
                            frame_count_q + {{(FRAME_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            frame_count_d = frame_count_q;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_q         <= IDLE_IN;
            vga_prev_q    <= IDLE_IN;
            h_cnt_q       <= {H_W{1'b0}};
            v_cnt_q       <= {V_W{1'b0}};
            state_q       <= MON_UNLOCKED;
            hs_seen_q     <= 1'b0;
            line_acc_q    <= 1'b0;
            crc_q         <= CRC_INIT;
            frame_valid_q <= 1'b0;
            frame_crc_q   <= {CRC_W{1'b0}};
            lines_seen_q  <= {V_W{1'b0}};
            frame_err_q   <= 1'b0;
            line_err_q    <= 1'b0;
            frame_count_q <= {FRAME_CNT_W{1'b0}};
        end else begin
            vga_q         <= vga_d;
            vga_prev_q    <= vga_prev_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            state_q       <= state_d;
            hs_seen_q     <= hs_seen_d;
            line_acc_q    <= line_acc_d;
            crc_q         <= crc_d;
            frame_valid_q <= frame_valid_d;
            frame_crc_q   <= frame_crc_d;
            lines_seen_q  <= lines_seen_d;
            frame_err_q   <= frame_err_d;
            line_err_q    <= line_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_crc   = frame_crc_q;
    assign lines_seen  = lines_seen_q;
    assign frame_err   = frame_err_q;
    assign line_err    = line_err_q;
    assign frame_count = frame_count_q;

endmodule
